// File: rtl/pwm_gen.sv
// pwm_gen: PWM output stage of the timer peripheral.
// Compares the live 8-bit counter value against double-buffered compare
// registers and drives one registered PWM output in left-aligned,
// right-aligned or range mode. Compare/mode settings are shadowed and only
// change at a counter period boundary or on the enable rising edge, so a
// software write never produces a glitched or truncated pulse.
//
// Output semantics: there is no handshake on this block. pwm_out is a level
// valid every cycle, and cycle_done is a one-cycle strobe (no ready/back-
// pressure) that marks the cycle after a period boundary was seen while the
// block was already enabled. Both outputs lag their inputs by exactly one clk.
module pwm_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_en,
  input  logic [1:0] functions,
  input  logic [7:0] compare1,
  input  logic [7:0] compare2,
  input  logic [7:0] period,
  input  logic       upnotdown,
  input  logic [7:0] count_val,
  output logic       pwm_out,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_RANGE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  logic [7:0] cmp1_sh;
  logic [7:0] cmp2_sh;
  mode_e      func_sh;
  logic [7:0] cnt_prev;
  logic       en_d;

  logic       wrap_evt;
  logic       en_rise;
  logic       load_evt;
  logic [7:0] eff_cmp1;
  logic [7:0] eff_cmp2;
  mode_e      eff_func;
  logic       pwm_next;

  // Boundary/load detection and selection of the settings in force this cycle.
  always_comb begin
    wrap_evt = 1'b0;
    en_rise  = 1'b0;
    load_evt = 1'b0;
    eff_cmp1 = cmp1_sh;
    eff_cmp2 = cmp2_sh;
    eff_func = func_sh;

    // Change detection keeps a prescaler-held boundary count from firing
    // repeatedly; the boundary value depends on counting direction.
    if (count_val != cnt_prev) begin
      if (upnotdown) begin
        wrap_evt = (count_val == 8'd0);
      end else begin
        wrap_evt = (count_val == period);
      end
    end

    en_rise  = pwm_en & ~en_d;
    // A disabled block never reloads its shadows.
    load_evt = pwm_en & (wrap_evt | en_rise);

    // New settings apply from the boundary count itself, not one count later.
    if (load_evt) begin
      eff_cmp1 = compare1;
      eff_cmp2 = compare2;
      eff_func = mode_e'(functions);
    end
  end

  // Compare the live count against the effective thresholds for the mode.
  always_comb begin
    pwm_next = 1'b0;
    case (eff_func)
      MODE_LEFT:  pwm_next = (count_val < eff_cmp1);
      MODE_RIGHT: pwm_next = (count_val >= eff_cmp1);
      MODE_RANGE: pwm_next = (count_val >= eff_cmp1) && (count_val < eff_cmp2);
      MODE_RSVD:  pwm_next = 1'b0;
      default:    pwm_next = 1'b0;
    endcase
  end

  // Register shadows, history and outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp1_sh    <= 8'd0;
      cmp2_sh    <= 8'd0;
      func_sh    <= MODE_LEFT;
      cnt_prev   <= 8'd0;
      en_d       <= 1'b0;
      pwm_out    <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      // Tracked even while disabled so re-enabling cannot see a stale count.
      cnt_prev <= count_val;
      en_d     <= pwm_en;
      if (load_evt) begin
        cmp1_sh <= compare1;
        cmp2_sh <= compare2;
        func_sh <= mode_e'(functions);
      end
      pwm_out    <= pwm_en & pwm_next;
      // The enable-edge load is not a period boundary, so it does not pulse.
      cycle_done <= wrap_evt & pwm_en & en_d;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen.
// A driver generates counter values (with prescale, soft resets and enable
// toggling), a reference model predicts each registered output and pushes it
// into exp_q; a monitor pops and compares one entry per clock. Directed
// scenarios also check pulse/high counts over whole periods.
module tb_pwm_gen;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_en = 1'b0;
  logic [1:0] functions = 2'b00;
  logic [7:0] compare1 = 8'd0;
  logic [7:0] compare2 = 8'd0;
  logic [7:0] period = 8'd9;
  logic       upnotdown = 1'b1;
  logic [7:0] count_val = 8'd0;
  logic       pwm_out;
  logic       cycle_done;

  always #5 clk = ~clk;

  pwm_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_en     (pwm_en),
    .functions  (functions),
    .compare1   (compare1),
    .compare2   (compare2),
    .period     (period),
    .upnotdown  (upnotdown),
    .count_val  (count_val),
    .pwm_out    (pwm_out),
    .cycle_done (cycle_done)
  );

  // ---------------- scoreboard state ----------------
  // entry = {clear_window, in_window, cycle_done, pwm_out}
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int win_hi = 0;
  int win_cd = 0;

  // reference model: settings currently in force, plus what it remembers
  logic [7:0] m_cmp1, m_cmp2, m_last;
  logic [1:0] m_func;
  logic       m_was_en;

  // counter generator state
  int psc = 0;
  int psc_cnt = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_level(input logic [1:0] f, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] cv);
    int v, a, b;
    v = int'(cv);
    a = int'(c1);
    b = int'(c2);
    case (f)
      2'b00:   return v < a;
      2'b01:   return v >= a;
      2'b10:   return (v >= a) && (v < b);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Predict the response to the inputs now on the pins, then let one clock
  // edge consume them.
  task automatic step(input bit win, input bit clr);
    logic boundary, load, exp_pwm, exp_cd;
    if (rst) begin
      m_cmp1 = 8'd0; m_cmp2 = 8'd0; m_func = 2'b00;
      m_last = 8'd0; m_was_en = 1'b0;
      exp_pwm = 1'b0; exp_cd = 1'b0;
    end else begin
      // a period boundary is arriving at the wrap value from somewhere else
      boundary = (count_val != m_last) &&
                 (upnotdown ? (count_val == 8'd0) : (count_val == period));
      load = pwm_en && (boundary || !m_was_en);
      if (load) begin
        m_cmp1 = compare1; m_cmp2 = compare2; m_func = functions;
      end
      exp_pwm  = pwm_en ? ref_level(m_func, m_cmp1, m_cmp2, count_val) : 1'b0;
      exp_cd   = boundary && pwm_en && m_was_en;
      m_last   = count_val;
      m_was_en = pwm_en;
    end
    exp_q.push_back({clr, win, exp_cd, exp_pwm});
    @(posedge clk);
    #2;
  endtask

  // advance the simulated prescaled up/down counter
  task automatic adv();
    if (psc_cnt >= psc) begin
      psc_cnt = 0;
      if (upnotdown) count_val = (count_val >= period) ? 8'd0 : count_val + 8'd1;
      else           count_val = (count_val == 8'd0) ? period : count_val - 8'd1;
    end else begin
      psc_cnt++;
    end
  endtask

  task automatic cyc(input bit win, input bit clr);
    step(win, clr);
    adv();
  endtask

  task automatic do_reset(input bit up);
    rst = 1'b1;
    upnotdown = up;
    count_val = 8'd0;
    psc_cnt = 0;
    step(0, 0);
    rst = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  // measure pwm high cycles and cycle_done pulses over n driven cycles
  task automatic window(input string name, input int n, input int hi_exp, input int cd_exp);
    cyc(1, 1);
    for (int i = 1; i < n; i++) cyc(1, 0);
    cyc(0, 0);
    check_eq({name, "_hi"}, win_hi, hi_exp);
    check_eq({name, "_cd"}, win_cd, cd_exp);
  endtask

  task automatic run_until_count(input logic [7:0] target);
    int guard;
    guard = 0;
    while (count_val != target && guard < 200) begin
      cyc(0, 0);
      guard++;
    end
    check_eq("reach_count", int'(count_val), int'(target));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[3]) begin
          win_hi = 0;
          win_cd = 0;
        end
        if (e[2]) begin
          win_hi += int'(pwm_out);
          win_cd += int'(cycle_done);
        end
        check_eq("pwm_out", int'(pwm_out), int'(e[0]));
        check_eq("cycle_done", int'(cycle_done), int'(e[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    do_reset(1'b1);
    step(0, 0);

    // left-aligned, period 9, compare1 3, no prescale
    period = 8'd9; psc = 0; functions = 2'b00; compare1 = 8'd3; pwm_en = 1'b1;
    do_reset(1'b1);
    settle(10);
    window("left", 30, 9, 3);

    // range 2..6, prescale 3: 16 high clocks and 1 pulse per 40 clocks
    psc = 3; functions = 2'b10; compare1 = 8'd2; compare2 = 8'd6;
    do_reset(1'b1);
    settle(40);
    window("range", 80, 32, 2);

    // mid-period write 3 -> 7 at count 5 waits for the next boundary
    psc = 0; functions = 2'b00; compare1 = 8'd3;
    do_reset(1'b1);
    run_until_count(8'd5);
    compare1 = 8'd7;
    window("midwrite_old", 5, 0, 0);   // counts 5..9, then count 0 drains
    window("midwrite_new", 9, 6, 0);   // counts 1..9 under compare1=7

    // down count, right-aligned, compare1 4
    functions = 2'b01; compare1 = 8'd4;
    do_reset(1'b0);
    settle(10);
    window("down_right", 30, 18, 3);

    // boundaries
    functions = 2'b00; compare1 = 8'd0;
    do_reset(1'b1);
    settle(12);
    window("left_c0", 20, 0, 2);
    compare1 = 8'd200;
    settle(12);
    window("left_c200", 20, 20, 2);
    functions = 2'b10; compare1 = 8'd6; compare2 = 8'd2;
    settle(12);
    window("range_inv", 20, 0, 2);
    functions = 2'b11; compare1 = 8'd0; compare2 = 8'd255;
    settle(12);
    window("reserved", 20, 0, 2);

    // reset mid-period while high, then enable-edge reload
    functions = 2'b00; compare1 = 8'd7; compare2 = 8'd0;
    do_reset(1'b1);
    run_until_count(8'd5);
    rst = 1'b1;
    cyc(1, 1);
    rst = 1'b0;
    cyc(0, 0);                          // enable rise at count 6, loads 7
    check_eq("rst_mid_hi", win_hi, 0);
    check_eq("rst_mid_cd", win_cd, 0);
    window("post_rst_tail", 3, 0, 0);   // counts 7..9, no pulse before wrap
    window("post_rst_full", 10, 7, 1);

    // randomized segments
    for (int seg = 0; seg < 12; seg++) begin
      period = 8'($urandom_range(3, 20));
      psc = $urandom_range(0, 2);
      functions = 2'($urandom_range(0, 3));
      compare1 = 8'($urandom_range(0, 24));
      compare2 = 8'($urandom_range(0, 24));
      pwm_en = 1'b1;
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 19) == 0) compare1 = 8'($urandom_range(0, 255) > 230 ? $urandom_range(0, 255) : $urandom_range(0, 24));
        if ($urandom_range(0, 19) == 0) compare2 = 8'($urandom_range(0, 24));
        if ($urandom_range(0, 29) == 0) functions = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) pwm_en = ~pwm_en;
        if (upnotdown && $urandom_range(0, 79) == 0) begin
          count_val = 8'd0;             // counter soft reset
          psc_cnt = 0;
        end
        rst = ($urandom_range(0, 149) == 0);
        cyc(0, 0);
      end
      rst = 1'b0;
    end

    // drain and confirm every prediction was consumed
    step(0, 0);
    step(0, 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

PWM output stage of the timer peripheral; sits directly downstream of the prescaled up/down counter and consumes its 8-bit count value. Compares the live count against two double-buffered compare registers and drives a single registered PWM output in one of three alignment modes. Compare and mode settings are shadowed and take effect only at a counter period boundary, so software writes never produce glitched or truncated pulses.

## Interface
Parameters:
- none; all datapaths are 8 bits, fixed to match the counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk
- pwm_en  in  1  block enable; low forces output to idle level
- functions  in  2  mode: 00 left-aligned, 01 right-aligned, 10 range, 11 reserved
- compare1  in  8  first compare threshold (software-written, unshadowed)
- compare2  in  8  second compare threshold, used in range mode only
- period  in  8  counter period, same value driven to the counter
- upnotdown  in  1  counter direction, same value driven to the counter
- count_val  in  8  live counter value
- pwm_out  out  1  registered PWM output
- cycle_done  out  1  single-cycle pulse marking a period boundary

## Operation
- State: shadow regs cmp1_sh, cmp2_sh, func_sh; cnt_prev (8b); en_d (pwm_en delayed 1 cycle); output regs pwm_out, cycle_done.
- Wrap event (combinational): `count_val != cnt_prev` AND (upnotdown ? `count_val == 0` : `count_val == period`). Change detection makes it fire once per wrap, even when the prescaler holds count_val for many cycles.
- Load event: wrap event OR (pwm_en AND NOT en_d) (enable rising edge).
- On load event: cmp1_sh <= compare1, cmp2_sh <= compare2, func_sh <= functions.
- Effective values (eff_*) = incoming compare1/compare2/functions when load event is active this cycle, else shadow values. A new setting is therefore applied from the boundary count itself.
- Compare using eff_* on count_val (all unsigned 8-bit):
  - 00 left-aligned: high when count_val < eff_cmp1; eff_cmp1 = 0 gives constant low; eff_cmp1 > period gives constant high.
  - 01 right-aligned: high when count_val >= eff_cmp1; eff_cmp1 = 0 gives constant high.
  - 10 range: high when eff_cmp1 <= count_val < eff_cmp2; eff_cmp1 >= eff_cmp2 gives constant low.
  - 11 reserved: low.
- pwm_en low: pwm_out <= 0, cycle_done <= 0, shadows hold, no load events.
- cnt_prev <= count_val every cycle regardless of pwm_en, so re-enable does not produce a false wrap.
- cycle_done <= wrap event AND pwm_en AND en_d. The enable-edge load does not pulse it.

## Timing
- Reset (rst high at clock edge): pwm_out = 0, cycle_done = 0, cmp1_sh = cmp2_sh = 0, func_sh = 00, cnt_prev = 0, en_d = 0. rst overrides all other inputs.
- Latency: pwm_out and cycle_done reflect count_val and controls with exactly 1 clk latency; no combinational path from inputs to outputs.
- Mid-period writes to compare1/compare2/functions have no effect on pwm_out until the next load event.
- Simultaneous enable rise and wrap: one load, no cycle_done pulse.
- Reset mid-period: outputs drop to 0 on the next edge. Shadows clear, so the first post-reset enable rise reloads them.
- Counter soft reset (count_val jumps to 0 while counting up) counts as a wrap: it loads shadows and pulses cycle_done.
- period change: takes effect immediately, because period is not shadowed here; the counter owns period buffering.

## Test plan
- Left-aligned, period=9, compare1=3, up count with prescale 0 -> pwm_out high for counts 0–2 and low for 3–9, delayed 1 clk; cycle_done pulses once per 10 clk.
- Range mode, compare1=2, compare2=6, period=9, prescale 3 (each count held 4 clk) -> pwm_out high for 16 clk per 40-clk period; cycle_done single 1-clk pulse per period.
- Mid-period write: compare1 3->7 while count_val=5 -> pwm_out unchanged until count returns to 0, then high for counts 0–6.
- Down count, period=9, right-aligned, compare1=4 -> wrap detected at count_val=9; pwm_out high for counts 9..4, low for 3..0.
- Boundaries: left-aligned compare1=0 -> constant 0; compare1=200 with period=9 -> constant 1; range mode with compare1=6, compare2=2 -> constant 0; functions=11 -> constant 0.
- Assert rst at count_val=5 with pwm_out=1 -> next edge pwm_out=0, cycle_done=0. pwm_en rise then loads the current compare1; no cycle_done until the following wrap.
